// File: rtl/psm_multi_domain_sequencer.sv
// Shared power sequencer: serialises power-up/down of NUM_DOM domains with a us prescaler,
// power-good/clock handshakes, per-step timeouts and per-domain fault lockout.
// Define PSM_SEQ_TELEMETRY_EN to add per-domain saturating transition counters on trans_cnt_o.
module psm_multi_domain_sequencer #(
  parameter int unsigned NUM_DOM        = 4,
  parameter int unsigned DW             = $clog2(NUM_DOM),
  parameter int unsigned CLK_PER_US     = 100,
  parameter int unsigned PWR_RAMP_US    = 50,
  parameter int unsigned ISO_SETUP_US   = 2,
  parameter int unsigned ACK_TIMEOUT_US = 1000,
  parameter int unsigned TW             = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [DW-1:0]         cmd_dom_i,
  input  logic                  cmd_on_i,
  input  logic                  cmd_ret_i,
  input  logic                  cmd_force_i,
  input  logic [NUM_DOM-1:0]    pgood_i,
  input  logic [NUM_DOM-1:0]    clk_ack_i,
  input  logic [NUM_DOM-1:0]    fatal_err_i,
  output logic [NUM_DOM-1:0]    pwr_sw_en_o,
  output logic [NUM_DOM-1:0]    iso_en_o,
  output logic [NUM_DOM-1:0]    rst_assert_o,
  output logic [NUM_DOM-1:0]    clk_en_o,
  output logic [NUM_DOM-1:0]    mem_ret_en_o,
  output logic [NUM_DOM-1:0]    clk_req_o,
  output logic [NUM_DOM-1:0]    dom_on_o,
  output logic [NUM_DOM-1:0]    dom_fault_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [7:0]            fault_code_o,
  output logic [TW-1:0]         last_us_o,
  output logic [NUM_DOM*16-1:0] trans_cnt_o
);

  localparam int unsigned PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PW-1:0] L_PRESC_MAX = PW'(CLK_PER_US - 1);
  localparam logic [TW-1:0] L_RAMP      = TW'(PWR_RAMP_US);
  localparam logic [TW-1:0] L_ISO       = TW'(ISO_SETUP_US);
  localparam logic [TW-1:0] L_TIMEOUT   = TW'(ACK_TIMEOUT_US);
  localparam logic [7:0]    FC_PU_SW    = 8'hA1;
  localparam logic [7:0]    FC_PU_CLK   = 8'hC1;
  localparam logic [7:0]    FC_PD_CLK   = 8'hC2;
  localparam logic [7:0]    FC_FATAL    = 8'hE1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PU_SW,
    S_PU_CLK,
    S_PU_ISO,
    S_PD_ISO,
    S_PD_CLK,
    S_PD_SW
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [PW-1:0]        r_presc;
  logic [TW-1:0]        r_step;
  logic [TW-1:0]        r_lat;
  logic [DW-1:0]        r_dom;
  logic                 r_ret;
  logic                 r_force;
  logic [NUM_DOM-1:0]   r_pwr_sw, r_iso, r_rst, r_clk_en, r_mem_ret, r_clk_req;
  logic [NUM_DOM-1:0]   r_dom_on, r_fault;
  logic                 r_done, r_err;
  logic [7:0]           r_fault_code;
  logic [TW-1:0]        r_last_us;

  logic                 w_us_tick;
  logic [NUM_DOM-1:0]   w_sel, w_cmd_sel;
  logic                 w_dom_valid, w_tgt_fault, w_tgt_on, w_tgt_fatal, w_force_ok;
  logic                 w_latch, w_timeout, w_abort;
  logic [7:0]           w_to_code;
  logic [NUM_DOM-1:0]   w_safe;
  logic [NUM_DOM-1:0]   w_pwr_sw_nxt, w_iso_nxt, w_rst_nxt, w_clk_en_nxt, w_mem_ret_nxt;
  logic [NUM_DOM-1:0]   w_clk_req_nxt, w_dom_on_nxt, w_fault_nxt;
  logic                 w_done_nxt, w_err_nxt;
  logic [7:0]           w_code_nxt;
  logic [TW-1:0]        w_last_us_nxt;

  assign w_us_tick = (r_presc == L_PRESC_MAX);

  // One-hot views of the active domain and of the incoming command target.
  always_comb begin
    w_sel     = '0;
    w_cmd_sel = '0;
    for (int unsigned d = 0; d < NUM_DOM; d++) begin
      w_sel[d]     = (r_dom == DW'(d));
      w_cmd_sel[d] = (cmd_dom_i == DW'(d));
    end
  end

  assign w_dom_valid = |w_cmd_sel;
  assign w_tgt_fault = |(w_cmd_sel & r_fault);
  assign w_tgt_on    = |(w_cmd_sel & r_dom_on);
  assign w_tgt_fatal = |(w_cmd_sel & fatal_err_i);
  assign w_force_ok  = cmd_force_i & ~cmd_on_i;

  always_comb begin
    w_state_nxt   = r_state;
    w_pwr_sw_nxt  = r_pwr_sw;
    w_iso_nxt     = r_iso;
    w_rst_nxt     = r_rst;
    w_clk_en_nxt  = r_clk_en;
    w_mem_ret_nxt = r_mem_ret;
    w_clk_req_nxt = r_clk_req;
    w_dom_on_nxt  = r_dom_on;
    w_fault_nxt   = r_fault;
    w_done_nxt    = 1'b0;
    w_err_nxt     = 1'b0;
    w_code_nxt    = r_fault_code;
    w_last_us_nxt = r_last_us;
    w_latch       = 1'b0;
    w_timeout     = 1'b0;
    w_to_code     = 8'h00;
    w_abort       = 1'b0;
    w_safe        = '0;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_latch = 1'b1;
          if (!w_dom_valid || w_tgt_fatal || (w_tgt_fault && !w_force_ok)) begin
            w_err_nxt = 1'b1;
          end else if (w_tgt_fault) begin
            w_fault_nxt = r_fault & ~w_cmd_sel;
            w_state_nxt = S_PD_ISO;
          end else if (cmd_on_i == w_tgt_on) begin
            w_done_nxt    = 1'b1;
            w_last_us_nxt = '0;
          end else begin
            w_state_nxt = cmd_on_i ? S_PU_SW : S_PD_ISO;
          end
        end
      end
      S_PU_SW: begin
        w_pwr_sw_nxt = r_pwr_sw | w_sel;
        if (r_step >= L_RAMP && |(pgood_i & w_sel)) begin
          w_state_nxt = S_PU_CLK;
        end else if (r_step >= L_TIMEOUT) begin
          w_timeout = 1'b1;
          w_to_code = FC_PU_SW;
        end
      end
      S_PU_CLK: begin
        w_clk_req_nxt = r_clk_req | w_sel;
        if (|(clk_ack_i & w_sel)) begin
          w_clk_en_nxt = r_clk_en | w_sel;
          w_state_nxt  = S_PU_ISO;
        end else if (r_step >= L_TIMEOUT) begin
          w_timeout = 1'b1;
          w_to_code = FC_PU_CLK;
        end
      end
      S_PU_ISO: begin
        if (r_step >= L_ISO) begin
          w_iso_nxt     = r_iso & ~w_sel;
          w_rst_nxt     = r_rst & ~w_sel;
          w_mem_ret_nxt = r_mem_ret & ~w_sel;
          w_dom_on_nxt  = r_dom_on | w_sel;
          w_done_nxt    = 1'b1;
          w_last_us_nxt = r_lat;
          w_state_nxt   = S_IDLE;
        end
      end
      S_PD_ISO: begin
        w_iso_nxt     = r_iso | w_sel;
        w_rst_nxt     = r_rst | w_sel;
        w_clk_en_nxt  = r_clk_en & ~w_sel;
        w_mem_ret_nxt = r_ret ? (r_mem_ret | w_sel) : (r_mem_ret & ~w_sel);
        if (r_step >= L_ISO) begin
          w_state_nxt = S_PD_CLK;
        end
      end
      S_PD_CLK: begin
        w_clk_req_nxt = r_clk_req & ~w_sel;
        if (!(|(clk_ack_i & w_sel))) begin
          w_state_nxt = S_PD_SW;
        end else if (r_step >= L_TIMEOUT && !r_force) begin
          // A force-clear keeps waiting: the domain is already in its safe state.
          w_timeout = 1'b1;
          w_to_code = FC_PD_CLK;
        end
      end
      S_PD_SW: begin
        w_pwr_sw_nxt  = r_pwr_sw & ~w_sel;
        w_dom_on_nxt  = r_dom_on & ~w_sel;
        w_done_nxt    = 1'b1;
        w_last_us_nxt = r_lat;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_timeout) begin
      w_safe     = w_sel;
      w_code_nxt = w_to_code;
      w_abort    = 1'b1;
    end

    // Fatal errors lock out any domain; only the active one aborts the sequence.
    if (|fatal_err_i) begin
      w_safe     = w_safe | fatal_err_i;
      w_code_nxt = FC_FATAL;
      if (r_state != S_IDLE && |(fatal_err_i & w_sel)) begin
        w_abort = 1'b1;
      end
    end

    if (w_abort) begin
      w_state_nxt   = S_IDLE;
      w_done_nxt    = 1'b0;
      w_last_us_nxt = r_last_us;
    end

    w_iso_nxt     = w_iso_nxt | w_safe;
    w_rst_nxt     = w_rst_nxt | w_safe;
    w_mem_ret_nxt = w_mem_ret_nxt | w_safe;
    w_clk_en_nxt  = w_clk_en_nxt & ~w_safe;
    w_clk_req_nxt = w_clk_req_nxt & ~w_safe;
    w_pwr_sw_nxt  = w_pwr_sw_nxt & ~w_safe;
    w_dom_on_nxt  = w_dom_on_nxt & ~w_safe;
    w_fault_nxt   = w_fault_nxt | w_safe;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_presc      <= '0;
      r_step       <= '0;
      r_lat        <= '0;
      r_dom        <= '0;
      r_ret        <= 1'b0;
      r_force      <= 1'b0;
      r_pwr_sw     <= '0;
      r_iso        <= '1;
      r_rst        <= '1;
      r_clk_en     <= '0;
      r_mem_ret    <= '1;
      r_clk_req    <= '0;
      r_dom_on     <= '0;
      r_fault      <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_fault_code <= '0;
      r_last_us    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_presc <= w_us_tick ? '0 : r_presc + PW'(1);
      if (w_state_nxt != r_state) begin
        r_step <= '0;
      end else if (w_us_tick && r_step != '1) begin
        r_step <= r_step + TW'(1);
      end
      if (w_latch) begin
        r_lat   <= '0;
        r_dom   <= cmd_dom_i;
        r_ret   <= cmd_ret_i;
        r_force <= w_force_ok & w_tgt_fault;
      end else if (w_us_tick && r_lat != '1) begin
        r_lat <= r_lat + TW'(1);
      end
      r_pwr_sw     <= w_pwr_sw_nxt;
      r_iso        <= w_iso_nxt;
      r_rst        <= w_rst_nxt;
      r_clk_en     <= w_clk_en_nxt;
      r_mem_ret    <= w_mem_ret_nxt;
      r_clk_req    <= w_clk_req_nxt;
      r_dom_on     <= w_dom_on_nxt;
      r_fault      <= w_fault_nxt;
      r_done       <= w_done_nxt;
      r_err        <= w_err_nxt;
      r_fault_code <= w_code_nxt;
      r_last_us    <= w_last_us_nxt;
    end
  end

`ifdef PSM_SEQ_TELEMETRY_EN
  logic [NUM_DOM*16-1:0] r_trans_cnt;

  // r_dom still names the completed domain during the done_o cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trans_cnt <= '0;
    end else if (r_done) begin
      for (int unsigned d = 0; d < NUM_DOM; d++) begin
        if (w_sel[d] && r_trans_cnt[d*16 +: 16] != 16'hFFFF) begin
          r_trans_cnt[d*16 +: 16] <= r_trans_cnt[d*16 +: 16] + 16'd1;
        end
      end
    end
  end

  assign trans_cnt_o = r_trans_cnt;
`else
  assign trans_cnt_o = '0;
`endif

  assign cmd_ready_o  = (r_state == S_IDLE);
  assign busy_o       = (r_state != S_IDLE);
  assign pwr_sw_en_o  = r_pwr_sw;
  assign iso_en_o     = r_iso;
  assign rst_assert_o = r_rst;
  assign clk_en_o     = r_clk_en;
  assign mem_ret_en_o = r_mem_ret;
  assign clk_req_o    = r_clk_req;
  assign dom_on_o     = r_dom_on;
  assign dom_fault_o  = r_fault;
  assign done_o       = r_done;
  assign err_o        = r_err;
  assign fault_code_o = r_fault_code;
  assign last_us_o    = r_last_us;

endmodule

// File: tb/tb_psm_multi_domain_sequencer.sv
// Directed bench for psm_multi_domain_sequencer: power-up/down, timeout, fatal lockout,
// force clear, rejections and mid-sequence reset, with hand-computed expectations.
module tb_psm_multi_domain_sequencer;
  localparam int unsigned NUM_DOM = 4;
  localparam int unsigned DW      = 3;
  localparam int unsigned CPU     = 4;
  localparam int unsigned TW      = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_on = 1'b0, cmd_ret = 1'b0, cmd_force = 1'b0;
  logic [DW-1:0] cmd_dom = '0;
  logic [NUM_DOM-1:0] pgood = '0, clk_ack = '0, fatal_err = '0;
  logic [NUM_DOM-1:0] pwr_sw_en, iso_en, rst_assert, clk_en, mem_ret_en, clk_req, dom_on, dom_fault;
  logic busy, done, err;
  logic [7:0] fault_code;
  logic [TW-1:0] last_us;
  logic [NUM_DOM*16-1:0] trans_cnt;

  int n_checks = 0;
  int n_fail = 0;
  int n_done = 0;
  int n_err = 0;
  int ack_cnt [NUM_DOM];
  int d0, e0, cyc;

  psm_multi_domain_sequencer #(
    .NUM_DOM(NUM_DOM), .DW(DW), .CLK_PER_US(CPU), .PWR_RAMP_US(3), .ISO_SETUP_US(2),
    .ACK_TIMEOUT_US(10), .TW(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_dom_i(cmd_dom), .cmd_on_i(cmd_on),
    .cmd_ret_i(cmd_ret), .cmd_force_i(cmd_force),
    .pgood_i(pgood), .clk_ack_i(clk_ack), .fatal_err_i(fatal_err),
    .pwr_sw_en_o(pwr_sw_en), .iso_en_o(iso_en), .rst_assert_o(rst_assert), .clk_en_o(clk_en),
    .mem_ret_en_o(mem_ret_en), .clk_req_o(clk_req), .dom_on_o(dom_on), .dom_fault_o(dom_fault),
    .busy_o(busy), .done_o(done), .err_o(err), .fault_code_o(fault_code),
    .last_us_o(last_us), .trans_cnt_o(trans_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse counters and a clock-ack responder that acks 1 us after clk_req, drops at once.
  initial forever begin
    @(negedge clk);
    if (done === 1'b1) n_done++;
    if (err === 1'b1) n_err++;
    for (int d = 0; d < NUM_DOM; d++) begin
      if (clk_req[d]) begin
        if (ack_cnt[d] == CPU - 1) clk_ack[d] = 1'b1;
        else ack_cnt[d]++;
      end else begin
        ack_cnt[d] = 0;
        clk_ack[d] = 1'b0;
      end
    end
  end

  task automatic send_cmd(input logic [DW-1:0] dom, input logic on, input logic ret,
                          input logic frc);
    cmd_dom = dom; cmd_on = on; cmd_ret = ret; cmd_force = frc; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_force = 1'b0; cmd_ret = 1'b0;
  endtask

  task automatic wait_idle(input string tag, output int n);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, 64'(cmd_ready), 64'(1'b1));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < NUM_DOM; d++) ack_cnt[d] = 0;
    repeat (3) @(negedge clk);
    check_eq("rst_iso", 64'(iso_en), 64'(4'hF));
    check_eq("rst_mem_ret", 64'(mem_ret_en), 64'(4'hF));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rst_assert", 64'(rst_assert), 64'(4'hF));
    check_eq("rst_ctrl_low", 64'({pwr_sw_en, clk_en, clk_req, dom_on, dom_fault}), 64'(0));
    check_eq("rst_flags", 64'({busy, done, err, cmd_ready}), 64'(4'b0001));
    check_eq("rst_code_lat", 64'({fault_code, last_us}), 64'(0));
    check_eq("rst_trans", 64'(trans_cnt), 64'(0));

    // Power-up domain 2.
    d0 = n_done;
    send_cmd(3'd2, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("pu2_sw_on", 64'(pwr_sw_en), 64'(4'b0100));
    check_eq("pu2_busy", 64'(busy), 64'(1'b1));
    repeat (2) @(negedge clk);
    pgood[2] = 1'b1;
    wait_idle("pu2_idle", cyc);
    check_eq("pu2_clk_en", 64'(clk_en), 64'(4'b0100));
    check_eq("pu2_iso", 64'({iso_en, rst_assert, mem_ret_en}), 64'({4'b1011, 4'b1011, 4'b1011}));
    check_eq("pu2_dom_on", 64'(dom_on), 64'(4'b0100));
    check_eq("pu2_done_cnt", 64'(n_done - d0), 64'(1));
    check_eq("pu2_last_us", 64'(last_us), 64'(6));

    // Power-up domain 1 with pgood stuck low: step timeout.
    d0 = n_done;
    send_cmd(3'd1, 1'b1, 1'b0, 1'b0);
    wait_idle("pu1_idle", cyc);
    check_eq("pu1_to_window", 64'(cyc >= 36 && cyc <= 44), 64'(1'b1));
    check_eq("pu1_fault", 64'(dom_fault), 64'(4'b0010));
    check_eq("pu1_code", 64'(fault_code), 64'(8'hA1));
    check_eq("pu1_safe", 64'({pwr_sw_en, iso_en, rst_assert, mem_ret_en, clk_req}),
             64'({4'b0100, 4'b1011, 4'b1011, 4'b1011, 4'b0100}));
    check_eq("pu1_no_done", 64'(n_done - d0), 64'(0));

    // Power-down domain 2 with retention.
    d0 = n_done;
    send_cmd(3'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("pd2_iso", 64'({iso_en, rst_assert, clk_en, mem_ret_en}),
             64'({4'hF, 4'hF, 4'h0, 4'hF}));
    check_eq("pd2_sw_held", 64'(pwr_sw_en), 64'(4'b0100));
    wait_idle("pd2_idle", cyc);
    check_eq("pd2_off", 64'({pwr_sw_en, clk_req, dom_on, mem_ret_en}),
             64'({4'h0, 4'h0, 4'h0, 4'hF}));
    check_eq("pd2_done_cnt", 64'(n_done - d0), 64'(1));
    check_eq("pd2_last_us", 64'(last_us), 64'(2));

    // Fatal error on domain 3 while domain 0 powers up.
    pgood[0] = 1'b1;
    d0 = n_done;
    send_cmd(3'd0, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    fatal_err[3] = 1'b1;
    @(negedge clk);
    fatal_err[3] = 1'b0;
    check_eq("fat_fault", 64'({dom_fault, fault_code}), 64'({4'b1010, 8'hE1}));
    check_eq("fat_busy", 64'(busy), 64'(1'b1));
    wait_idle("fat_idle", cyc);
    check_eq("fat_d0_on", 64'({dom_on, pwr_sw_en, iso_en}), 64'({4'b0001, 4'b0001, 4'b1110}));
    check_eq("fat_d0_done", 64'(n_done - d0), 64'(1));
    e0 = n_err;
    d0 = n_done;
    send_cmd(3'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("fat_on_rej", 64'(n_err - e0), 64'(1));
    check_eq("fat_on_nodone", 64'({n_done - d0, busy}), 64'(0));
    d0 = n_done;
    send_cmd(3'd3, 1'b0, 1'b0, 1'b1);
    wait_idle("force_idle", cyc);
    check_eq("force_fault", 64'(dom_fault), 64'(4'b0010));
    check_eq("force_done", 64'(n_done - d0), 64'(1));
    check_eq("force_mem_ret", 64'({mem_ret_en, iso_en}), 64'({4'b0110, 4'b1110}));

    // Out-of-range domain, then a no-op power-up of an already-on domain.
    e0 = n_err;
    d0 = n_done;
    send_cmd(3'd5, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_eq("bad_dom_err", 64'(n_err - e0), 64'(1));
    check_eq("bad_dom_nodone", 64'(n_done - d0), 64'(0));
    d0 = n_done;
    send_cmd(3'd0, 1'b1, 1'b0, 1'b0);
    check_eq("noop_done_now", 64'({done, busy}), 64'(2'b10));
    @(negedge clk);
    check_eq("noop_unchanged", 64'({pwr_sw_en, iso_en, clk_en, dom_on, done}),
             64'({4'b0001, 4'b1110, 4'b0001, 4'b0001, 1'b0}));
    check_eq("noop_done_cnt", 64'(n_done - d0), 64'(1));
`ifdef PSM_SEQ_TELEMETRY_EN
    check_eq("telemetry", 64'(trans_cnt), 64'({16'd1, 16'd2, 16'd0, 16'd2}));
`else
    check_eq("telemetry", 64'(trans_cnt), 64'(0));
`endif

    // Reset in the middle of a power-up, then a clean retry.
    send_cmd(3'd2, 1'b1, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_hi", 64'({iso_en, rst_assert, mem_ret_en}), 64'(12'hFFF));
    check_eq("mid_rst_lo", 64'({pwr_sw_en, clk_en, clk_req, dom_on, dom_fault}), 64'(0));
    check_eq("mid_rst_misc", 64'({busy, done, err, cmd_ready, fault_code, last_us, trans_cnt}),
             64'({4'b0001, 8'h00, 16'h0000, 64'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d0 = n_done;
    send_cmd(3'd2, 1'b1, 1'b0, 1'b0);
    wait_idle("retry_idle", cyc);
    check_eq("retry_on", 64'({dom_on, dom_fault}), 64'({4'b0100, 4'b0000}));
    check_eq("retry_done", 64'(n_done - d0), 64'(1));
    check_eq("retry_last_us", 64'(last_us), 64'(6));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/psm_multi_domain_sequencer.md
Name: psm_multi_domain_sequencer

Overview:
- Parametrised successor to the per-domain power state machine.
- One shared sequencer serialises power-up and power-down across NUM_DOM domains, so only one domain ramps at a time (inrush limiting).
- Has a built-in microsecond prescaler and a power-good handshake, with per-step timeouts and per-domain fault lockout.
- Sits between the firmware power manager and the PMIC/UPF controls plus the clock subsystem.

Parameters:
- NUM_DOM, 4, number of domains (≥2).
- DW, $clog2(NUM_DOM), domain index width.
- CLK_PER_US, 100, clk cycles per microsecond tick.
- PWR_RAMP_US, 50, minimum µs after switch-on before power-good is accepted.
- ISO_SETUP_US, 2, µs between clock-enable and isolation release, and between isolation and clock-off.
- ACK_TIMEOUT_US, 1000, µs limit per handshake step.
- TW, 16, timer and latency width; all timers saturate at all-ones.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command ready; high only in S_IDLE
- cmd_dom_i  in  DW  target domain
- cmd_on_i  in  1  1 = power up, 0 = power down
- cmd_ret_i  in  1  power-down only: keep mem_ret_en high while off
- cmd_force_i  in  1  clears a faulted domain (valid only with cmd_on_i=0)
- pgood_i  in  NUM_DOM  per-domain power-good
- clk_ack_i  in  NUM_DOM  per-domain clock-stable acknowledge
- fatal_err_i  in  NUM_DOM  per-domain fatal error
- pwr_sw_en_o, iso_en_o, rst_assert_o, clk_en_o, mem_ret_en_o, clk_req_o  out  NUM_DOM each  per-domain controls
- dom_on_o  out  NUM_DOM  domain fully on
- dom_fault_o  out  NUM_DOM  domain locked out
- busy_o  out  1  sequencer not idle
- done_o  out  1  one-cycle pulse when a command completes
- err_o  out  1  one-cycle pulse when a command is rejected
- fault_code_o  out  8  last fault code (sticky)
- last_us_o  out  TW  µs from acceptance to done of the last completed command
- trans_cnt_o  out  NUM_DOM*16  telemetry (see Optional Feature)

Behaviour:
- Reset values:
  - iso_en_o, rst_assert_o, mem_ret_en_o: all 1.
  - pwr_sw_en_o, clk_en_o, clk_req_o, dom_on_o, dom_fault_o: all 0.
  - busy_o, done_o, err_o: 0. fault_code_o, last_us_o, trans_cnt_o: 0.
  - cmd_ready_o: 1. Prescaler: 0.
- Prescaler: free-running counter 0..CLK_PER_US-1. us_tick is high on the count CLK_PER_US-1.
- Step timer: cleared on every state entry; +1 per us_tick.
- Latency counter: cleared on command acceptance; +1 per us_tick.
- Handshake: command accepted when cmd_valid_i & cmd_ready_o. Inputs are latched at acceptance; busy_o goes high the next cycle.
- Immediate rejection (err_o pulse next cycle, stay in S_IDLE):
  - cmd_dom_i ≥ NUM_DOM.
  - Target domain faulted and not (cmd_force_i & !cmd_on_i).
- Target already in the requested state: done_o pulses the next cycle; outputs unchanged.
- Power-up states:
  - S_PU_SW: pwr_sw_en=1. Leave when step timer ≥ PWR_RAMP_US and pgood=1. Step timer ≥ ACK_TIMEOUT_US → fault 0xA1.
  - S_PU_CLK: clk_req=1. On clk_ack, set clk_en=1. Timeout → fault 0xC1.
  - S_PU_ISO: after ISO_SETUP_US, clear iso_en, rst_assert and mem_ret_en; set dom_on=1; pulse done_o; go to S_IDLE.
- Power-down states:
  - S_PD_ISO: iso_en=1, rst_assert=1, clk_en=0, mem_ret_en=cmd_ret_i. Wait ISO_SETUP_US.
  - S_PD_CLK: clk_req=0; wait until clk_ack=0. Timeout → fault 0xC2.
  - S_PD_SW: pwr_sw_en=0, dom_on=0; pulse done_o; go to S_IDLE.
- Faults:
  - Any timeout or fatal_err_i[d] forces domain d safe: iso=1, rst=1, clk_en=0, clk_req=0, pwr_sw=0, mem_ret=1.
  - Also sets dom_fault[d]=1 and dom_on[d]=0, and loads fault_code (0xE1 for fatal error).
  - If the active domain faults, the sequencer goes to S_IDLE with no done_o pulse.
  - fatal_err_i on a non-active domain does not disturb the active sequence.
- Fatal error on the target in the acceptance cycle: fatal wins; the command is dropped and err_o pulses.
- Force clear (cmd_force_i with cmd_on_i=0 on a faulted domain):
  - Clears dom_fault.
  - Runs the normal power-down sequence with timeouts ignored.
  - Pulses done_o.
- Outputs are registered; a latch change appears 1 cycle after the state/step transition.
- last_us_o is updated with the latency count in the done_o cycle; it saturates.

Optional Feature:
- Macro: PSM_SEQ_TELEMETRY_EN.
- Defined: trans_cnt_o slice d is a 16-bit saturating count of completed transitions (done_o) for domain d, reset to 0.
- Undefined: trans_cnt_o is tied to 0 and no counter flops are present.

Test Plan:
All scenarios use CLK_PER_US=4, PWR_RAMP_US=3, ISO_SETUP_US=2, ACK_TIMEOUT_US=10, NUM_DOM=4.
- Power-up dom 2, with pgood=1 at 1 µs and clk_ack 1 µs after clk_req → pwr_sw_en_o=0100, then clk_en_o=0100, then iso/rst cleared on bit 2; dom_on_o=0100, done_o pulses once, last_us_o=6.
- Power-up dom 1 with pgood held 0 → fault at step 10 µs: dom_fault_o=0010, fault_code_o=0xA1, dom 1 safe, no done_o, cmd_ready_o=1.
- Power-down dom 2 with cmd_ret_i=1 → iso_en=1, clk_en=0, clk_req drop, then pwr_sw_en_o[2]=0 with mem_ret_en_o[2]=1; done_o pulses.
- fatal_err_i[3] during dom 0 power-up → dom 3 safe, fault_code_o=0xE1; dom 0 still completes; a later on-command to dom 3 gives err_o, and a force-off clears dom_fault_o[3] and pulses done_o.
- cmd_dom_i=5 → err_o pulse; cmd to a domain already on → done_o next cycle with no output change.
- Assert rst_n mid power-up → all outputs at reset values the same cycle; a fresh command after release succeeds.
